// File: rtl/compressor_pkg.sv
// 4:2 compressor row: shared types, cell equations
// and configuration checks.
package compressor_pkg;

  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } mode_t;

  typedef struct packed {
    logic s;
    logic c;
    logic cout;
  } cell_out_t;

  function automatic cell_out_t cell_exact(
    input logic [4:1] x,
    input logic       cin
  );
    cell_out_t r;
    logic      p;
    p      = ^x;
    r.s    = p ^ cin;
    r.c    = p ? cin : x[4];
    r.cout = (x[1] ^ x[2]) ? x[3] : x[1];
    return r;
  endfunction

  function automatic cell_out_t cell_approx(
    input logic [4:1] x
  );
    cell_out_t r;
    r.s    = (x[1] ^ x[2]) | (x[3] ^ x[4]);
    r.c    = (x[1] & x[2]) | (x[3] & x[4]);
    r.cout = 1'b0;
    return r;
  endfunction

  function automatic bit params_ok(
    input int w,
    input int ac,
    input int st
  );
    return (w >= 4) && (w % 2 == 0) &&
           (ac >= 0) && (ac <= w) &&
           (st == 1 || st == 2);
  endfunction

endpackage

// File: rtl/compressor42_cell.sv
// One 4:2 compressor column, exact or
// approximate per approx_en.
module compressor42_cell
  import compressor_pkg::*;
(
  input  logic [4:1] x,
  input  logic       cin,
  input  logic       approx_en,
  output logic       s,
  output logic       c,
  output logic       cout
);

  cell_out_t w_e;
  cell_out_t w_a;
  cell_out_t w_r;

  always_comb begin
    w_e = cell_exact(x, cin);
    w_a = cell_approx(x);
    w_r = approx_en ? w_a : w_e;
  end

  assign s    = w_r.s;
  assign c    = w_r.c;
  assign cout = w_r.cout;

endmodule

// File: rtl/compressor42_row_pipe.sv
// Pipelined row of 4:2 compressors with a
// valid/ready handshake, 1 or 2 stages.
module compressor42_row_pipe
  import compressor_pkg::*;
#(
  parameter int W           = 8,
  parameter int APPROX_COLS = 4,
  parameter int STAGES      = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  input  logic [W-1:0] d_i,
  input  logic         mode_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   sum_o,
  output logic [W:0]   carry_o,
  output logic         mode_o
);

  localparam int H    = W / 2;
  localparam bit P_OK =
    params_ok(W, APPROX_COLS, STAGES);

  if (!P_OK) begin : g_bad_cfg
    $error("compressor42_row_pipe: bad params");
  end

  logic [W-1:0] w_x1, w_x2, w_x3, w_x4;
  logic [W-1:0] w_cin;
  logic [W-1:0] w_colmode;
  logic [W-1:0] w_aen;
  logic [W-1:0] w_s, w_c, w_co;

  logic         r_vo;
  logic [W:0]   r_sum;
  logic [W:0]   r_car;
  mode_t        r_mo;

  assign out_valid = r_vo;
  assign sum_o     = r_sum;
  assign carry_o   = r_car;
  assign mode_o    = r_mo;

  for (genvar i = 0; i < W; i++) begin : g_col
    localparam bit APX = (i < APPROX_COLS);
    assign w_aen[i] = APX & w_colmode[i];
    compressor42_cell u_cell (
      .x        ({w_x4[i], w_x3[i],
                  w_x2[i], w_x1[i]}),
      .cin      (w_cin[i]),
      .approx_en(w_aen[i]),
      .s        (w_s[i]),
      .c        (w_c[i]),
      .cout     (w_co[i])
    );
  end

  if (STAGES == 2) begin : g_two
    logic         r_v1;
    logic [H-1:0] r_s1;
    logic [H-1:0] r_c1;
    logic         r_co1;
    logic [W-1:H] r_a1, r_b1, r_c1i, r_d1;
    mode_t        r_m1;
    logic         w_adv1;
    logic         w_adv2;

    assign w_adv2   = !r_vo | out_ready;
    assign w_adv1   = !r_v1 | w_adv2;
    assign in_ready = w_adv1;

    // low half from the inputs, high half from stage 1
    assign w_x1 = {r_a1,  a_i[H-1:0]};
    assign w_x2 = {r_b1,  b_i[H-1:0]};
    assign w_x3 = {r_c1i, c_i[H-1:0]};
    assign w_x4 = {r_d1,  d_i[H-1:0]};
    assign w_cin = {w_co[W-2:H], r_co1,
                    w_co[H-2:0], 1'b0};
    assign w_colmode = {
      {(W-H){r_m1 == MODE_APPROX}},
      {H{mode_i}}
    };

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v1  <= 1'b0;
        r_s1  <= '0;
        r_c1  <= '0;
        r_co1 <= 1'b0;
        r_a1  <= '0;
        r_b1  <= '0;
        r_c1i <= '0;
        r_d1  <= '0;
        r_m1  <= MODE_EXACT;
      end else if (w_adv1) begin
        r_v1 <= in_valid;
        if (in_valid) begin
          r_s1  <= w_s[H-1:0];
          r_c1  <= w_c[H-1:0];
          r_co1 <= w_co[H-1];
          r_a1  <= a_i[W-1:H];
          r_b1  <= b_i[W-1:H];
          r_c1i <= c_i[W-1:H];
          r_d1  <= d_i[W-1:H];
          r_m1  <= mode_t'(mode_i);
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vo  <= 1'b0;
        r_sum <= '0;
        r_car <= '0;
        r_mo  <= MODE_EXACT;
      end else if (w_adv2) begin
        r_vo <= r_v1;
        if (r_v1) begin
          r_sum <= {w_co[W-1], w_s[W-1:H], r_s1};
          r_car <= {w_c[W-1:H], r_c1, 1'b0};
          r_mo  <= r_m1;
        end
      end
    end
  end else begin : g_one
    logic w_adv;

    assign w_adv    = !r_vo | out_ready;
    assign in_ready = w_adv;

    assign w_x1      = a_i;
    assign w_x2      = b_i;
    assign w_x3      = c_i;
    assign w_x4      = d_i;
    assign w_cin     = {w_co[W-2:0], 1'b0};
    assign w_colmode = {W{mode_i}};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vo  <= 1'b0;
        r_sum <= '0;
        r_car <= '0;
        r_mo  <= MODE_EXACT;
      end else if (w_adv) begin
        r_vo <= in_valid;
        if (in_valid) begin
          r_sum <= {w_co[W-1], w_s};
          r_car <= {w_c, 1'b0};
          r_mo  <= mode_t'(mode_i);
        end
      end
    end
  end

endmodule

// File: tb/tb_compressor42_row_pipe.sv
// Directed bench for the 4:2 compressor row,
// 1- and 2-stage builds plus a full-approx build.
module tb_compressor42_row_pipe;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic         mode;
  logic [W-1:0] a, b, c, d;
  int           sel;

  logic [2:0]        iv, ir, ov, mo;
  logic [2:0][W:0]   sm, cr;

  logic              o_ir, o_ov, o_mo;
  logic [W:0]        o_sm, o_cr;

  int checks = 0;
  int fails  = 0;

  assign iv = {in_valid && sel == 2,
               in_valid && sel == 1,
               in_valid && sel == 0};
  assign o_ir = ir[sel];
  assign o_ov = ov[sel];
  assign o_mo = mo[sel];
  assign o_sm = sm[sel];
  assign o_cr = cr[sel];

  compressor42_row_pipe #(
    .W(W), .APPROX_COLS(4), .STAGES(1)
  ) u_s1 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .a_i(a), .b_i(b), .c_i(c), .d_i(d),
    .mode_i(mode),
    .out_valid(ov[0]), .out_ready(out_ready),
    .sum_o(sm[0]), .carry_o(cr[0]),
    .mode_o(mo[0])
  );

  compressor42_row_pipe #(
    .W(W), .APPROX_COLS(4), .STAGES(2)
  ) u_s2 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .a_i(a), .b_i(b), .c_i(c), .d_i(d),
    .mode_i(mode),
    .out_valid(ov[1]), .out_ready(out_ready),
    .sum_o(sm[1]), .carry_o(cr[1]),
    .mode_o(mo[1])
  );

  compressor42_row_pipe #(
    .W(W), .APPROX_COLS(W), .STAGES(1)
  ) u_full (
    .clk(clk), .rst(rst),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .a_i(a), .b_i(b), .c_i(c), .d_i(d),
    .mode_i(mode),
    .out_valid(ov[2]), .out_ready(out_ready),
    .sum_o(sm[2]), .carry_o(cr[2]),
    .mode_o(mo[2])
  );

  function automatic int lat_of(input int s);
    return (s == 1) ? 2 : 1;
  endfunction

  function automatic int tot(
    input logic [W:0] s,
    input logic [W:0] k
  );
    return int'(s) + int'(k);
  endfunction

  function automatic int osum(
    input logic [W-1:0] p, q, r, t
  );
    return int'(p) + int'(q) + int'(r) + int'(t);
  endfunction

  task automatic one_beat(
    input  logic [W-1:0] ta, tb, tc, td,
    input  logic         tm,
    output logic [W:0]   rs,
    output logic [W:0]   rc,
    output logic         rm,
    output int           rl
  );
    @(negedge clk);
    a = ta; b = tb; c = tc; d = td;
    mode = tm; in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rl = 1;
    while (!o_ov && rl < 20) begin
      @(negedge clk);
      rl++;
    end
    #1;
    rs = o_sm; rc = o_cr; rm = o_mo;
  endtask

  task automatic test_reset;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ov[k] !== 1'b0 || sm[k] !== '0 ||
          cr[k] !== '0 || mo[k] !== 1'b0) begin
        fails++;
        $display("FAIL reset_state inst=%0d ov=%b sum=%h carry=%h mode=%b exp 0",
                 k, ov[k], sm[k], cr[k], mo[k]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (ir !== 3'b111) begin
      fails++;
      $display("FAIL reset_in_ready got=%b exp=111", ir);
    end
  endtask

  task automatic test_exact;
    logic [W:0] rs, rc;
    logic       rm;
    int         rl;
    one_beat(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0,
             rs, rc, rm, rl);
    checks++;
    if (tot(rs, rc) != 1020 || rm !== 1'b0) begin
      fails++;
      $display("FAIL exact_ff sel=%0d got=%0d mode=%b exp=1020 mode=0",
               sel, tot(rs, rc), rm);
    end
    checks++;
    if (rl != lat_of(sel)) begin
      fails++;
      $display("FAIL latency sel=%0d got=%0d exp=%0d",
               sel, rl, lat_of(sel));
    end
    one_beat(8'hA5, 8'h3C, 8'h0F, 8'hF0, 1'b0,
             rs, rc, rm, rl);
    checks++;
    if (tot(rs, rc) != 480) begin
      fails++;
      $display("FAIL exact_mix sel=%0d got=%0d exp=480",
               sel, tot(rs, rc));
    end
  endtask

  task automatic test_approx;
    logic [W:0] rs, rc;
    logic       rm;
    int         rl;
    one_beat(8'h01, 8'h01, 8'h01, 8'h01, 1'b1,
             rs, rc, rm, rl);
    checks++;
    if (tot(rs, rc) != 2 || rm !== 1'b1) begin
      fails++;
      $display("FAIL approx_01 sel=%0d got=%0d mode=%b exp=2 mode=1",
               sel, tot(rs, rc), rm);
    end
    one_beat(8'h01, 8'h01, 8'h01, 8'h01, 1'b0,
             rs, rc, rm, rl);
    checks++;
    if (tot(rs, rc) != 4 || rm !== 1'b0) begin
      fails++;
      $display("FAIL exact_01 sel=%0d got=%0d mode=%b exp=4 mode=0",
               sel, tot(rs, rc), rm);
    end
    one_beat(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1,
             rs, rc, rm, rl);
    checks++;
    if (rs !== 9'h1E0 || rc !== 9'h1FE) begin
      fails++;
      $display("FAIL approx_ff sel=%0d got sum=%h carry=%h exp sum=1e0 carry=1fe",
               sel, rs, rc);
    end
  endtask

  task automatic test_approx_full;
    logic [W:0] rs, rc;
    logic       rm;
    int         rl;
    one_beat(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1,
             rs, rc, rm, rl);
    checks++;
    if (rs !== 9'h000 || rc !== 9'h1FE) begin
      fails++;
      $display("FAIL full_approx_ff got sum=%h carry=%h exp sum=000 carry=1fe",
               rs, rc);
    end
    one_beat(8'h01, 8'h01, 8'h01, 8'h01, 1'b1,
             rs, rc, rm, rl);
    checks++;
    if (tot(rs, rc) != 2) begin
      fails++;
      $display("FAIL full_approx_01 got=%0d exp=2",
               tot(rs, rc));
    end
  endtask

  task automatic test_stream(
    input int    n,
    input int    rpct,
    input int    vpct,
    input string tag
  );
    int q[$];
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    int last = -1;
    int e;
    bit acc  = 1'b0;
    bit b2b;
    b2b = (rpct == 100) && (vpct == 100);
    mode = 1'b0;
    while (got < n && cyc < n * 8 + 50) begin
      @(negedge clk);
      if (acc || !in_valid) begin
        if (sent < n &&
            $urandom_range(99) < vpct) begin
          a = W'($urandom);
          b = W'($urandom);
          c = W'($urandom);
          d = W'($urandom);
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(99) < rpct);
      #1;
      acc = in_valid && o_ir;
      if (b2b && sent < n) begin
        checks++;
        if (o_ir !== 1'b1) begin
          fails++;
          $display("FAIL %s_in_ready sel=%0d cyc=%0d got=%b exp=1",
                   tag, sel, cyc, o_ir);
        end
      end
      if (o_ov && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL %s_extra sel=%0d got=%0d exp=none",
                   tag, sel, tot(o_sm, o_cr));
        end else begin
          e = q.pop_front();
          if (tot(o_sm, o_cr) != e) begin
            fails++;
            $display("FAIL %s_data sel=%0d beat=%0d got=%0d exp=%0d",
                     tag, sel, got, tot(o_sm, o_cr), e);
          end
        end
        got++;
        last = cyc;
      end
      if (acc) begin
        q.push_back(osum(a, b, c, d));
        sent++;
      end
      cyc++;
    end
    checks++;
    if (got != n) begin
      fails++;
      $display("FAIL %s_count sel=%0d got=%0d exp=%0d",
               tag, sel, got, n);
    end
    if (b2b) begin
      checks++;
      if (last != n - 1 + lat_of(sel)) begin
        fails++;
        $display("FAIL %s_rate sel=%0d last=%0d exp=%0d",
                 tag, sel, last, n - 1 + lat_of(sel));
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (o_ov !== 1'b0) begin
      fails++;
      $display("FAIL %s_dup sel=%0d out_valid=%b exp=0",
               tag, sel, o_ov);
    end
  endtask

  task automatic test_stall;
    int         q[$];
    int         lat;
    int         got = 0;
    int         e;
    bit         acc = 1'b0;
    logic [W:0] hs, hc;
    lat = lat_of(sel);
    mode = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      a = W'(8'h10 + k); b = W'(8'h21 * k);
      c = W'(8'hF3 - k); d = W'(8'h47 + 3 * k);
      in_valid = 1'b1;
      #1;
      if (k < lat) begin
        checks++;
        if (o_ir !== 1'b1) begin
          fails++;
          $display("FAIL stall_fill sel=%0d k=%0d in_ready=%b exp=1",
                   sel, k, o_ir);
        end
        q.push_back(osum(a, b, c, d));
      end
    end
    for (int j = 0; j < 16; j++) begin
      if (j > 0) @(negedge clk);
      if (acc) in_valid = 1'b0;
      out_ready = (j >= 5);
      #1;
      if (j == 0) begin
        hs = o_sm;
        hc = o_cr;
      end
      if (j < 5) begin
        checks++;
        if (o_ir !== 1'b0 || o_ov !== 1'b1 ||
            o_sm !== hs || o_cr !== hc) begin
          fails++;
          $display("FAIL stall_hold sel=%0d j=%0d in_ready=%b out_valid=%b sum=%h carry=%h exp 0 1 %h %h",
                   sel, j, o_ir, o_ov, o_sm, o_cr, hs, hc);
        end
      end else if (o_ov) begin
        checks++;
        e = (q.size() > 0) ? q.pop_front() : -1;
        if (tot(o_sm, o_cr) != e) begin
          fails++;
          $display("FAIL stall_drain sel=%0d beat=%0d got=%0d exp=%0d",
                   sel, got, tot(o_sm, o_cr), e);
        end
        got++;
      end
      acc = in_valid && o_ir;
      if (acc) q.push_back(osum(a, b, c, d));
    end
    checks++;
    if (got != lat + 1) begin
      fails++;
      $display("FAIL stall_count sel=%0d got=%0d exp=%0d",
               sel, got, lat + 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [W:0] rs, rc;
    logic       rm;
    int         rl;
    int         extra = 0;
    out_ready = 1'b0;
    mode = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      a = W'(8'h33 + k); b = 8'h44;
      c = 8'h55; d = 8'h66;
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (o_ov !== 1'b0 || o_sm !== '0 ||
        o_cr !== '0 || o_mo !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid sel=%0d ov=%b sum=%h carry=%h mode=%b exp 0",
               sel, o_ov, o_sm, o_cr, o_mo);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (o_ir !== 1'b1) begin
      fails++;
      $display("FAIL rst_release_ready sel=%0d got=%b exp=1",
               sel, o_ir);
    end
    one_beat(8'h12, 8'h34, 8'h56, 8'h78, 1'b0,
             rs, rc, rm, rl);
    checks++;
    if (tot(rs, rc) != 276 || rl != lat_of(sel)) begin
      fails++;
      $display("FAIL rst_after sel=%0d got=%0d lat=%0d exp=276 lat=%0d",
               sel, tot(rs, rc), rl, lat_of(sel));
    end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      #1;
      if (o_ov) extra++;
    end
    checks++;
    if (extra != 0) begin
      fails++;
      $display("FAIL rst_stale sel=%0d got=%0d exp=0",
               sel, extra);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    mode = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    sel = 0;
    repeat (3) @(negedge clk);
    test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s;
      test_exact();
      test_approx();
      test_stream(16, 100, 100, "b2b");
      test_stall();
      test_stream(10000, 70, 80, "sweep");
      test_reset_mid();
    end
    sel = 2;
    test_exact();
    test_approx_full();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/compressor42_row_pipe.md
# compressor42_row_pipe

Parametrised, pipelined row of 4:2 compressors. It reduces four W-bit partial-product operands to a sum/carry vector pair that feeds the multiplier's final adder. Per beat, the low APPROX_COLS columns run either exact or approximate cells. The row carries a valid/ready handshake so it can sit between partial-product generation and the final carry-propagate adder under backpressure.

## Interface
- W, default 8: operand width (≥ 4, even).
- APPROX_COLS, default 4: number of low-order columns switchable to approximate cells (0..W).
- STAGES, default 1: pipeline depth (1 or 2).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  row can accept a beat this cycle.
- a_i, b_i, c_i, d_i  in  W each  operands (cell inputs a1..a4 respectively).
- mode_i  in  1  0 = exact all columns, 1 = approximate in columns 0..APPROX_COLS-1.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- sum_o  out  W+1  bits 0..W-1 = cell s, bit W = final column cout.
- carry_o  out  W+1  bit 0 = 0, bit i+1 = cell c of column i.
- mode_o  out  1  mode_i of the beat being presented.

## Operation
- Column i takes x1..x4 = a_i[i], b_i[i], c_i[i], d_i[i] and cin. Column 0 cin = 0; column i+1 cin = cout of column i.
- Exact cell: p = x1^x2^x3^x4; s = p^cin; c = p ? cin : x4; cout = (x1^x2) ? x3 : x1. Invariant: x1+x2+x3+x4+cin = s + 2(c+cout).
- Approximate cell: s = (x1^x2)|(x3^x4); c = (x1&x2)|(x3&x4); cout = 0; cin ignored.
- Exact beat: sum_o + carry_o (W+2-bit add) == a_i+b_i+c_i+d_i exactly.
- mode_i and data are captured together. Mode is a per-beat property, with no global mode register.
- Handshake: a beat transfers on in_valid & in_ready and on out_valid & out_ready. Data and mode are stable while valid & !ready. No beat is dropped or duplicated.
- Each stage register advances when it is empty or the next stage/output is being consumed, so in_ready = !valid_s1 | advance_s1. The pipeline sustains 1 beat/cycle with out_ready held high.
- STAGES=2: stage 1 evaluates columns 0..W/2-1. It registers their s/c, the cout of column W/2-1, the upper operand halves, and mode. Stage 2 evaluates columns W/2..W-1 using the registered cout as cin.

## Timing
- Latency: STAGES cycles from input handshake to out_valid.
- Reset asserted (async): out_valid=0, sum_o=0, carry_o=0, mode_o=0, all stage valids 0. in_ready=1 once out of reset. In-flight beats are discarded.
- Reset release: first accept possible on the first rising edge with rst low.
- Simultaneous: with output consumed and a new input accepted in the same cycle, the stage reloads with no bubble.
- Stall: out_ready low with all stages full drives in_ready low in the same cycle (combinational from out_ready). Outputs hold.
- APPROX_COLS=0: mode_i has no effect on the result; mode_o still passes through.
- APPROX_COLS=W: final cout = 0 in approx mode.

## Structure
- Package compressor_pkg: enum mode_t {MODE_EXACT, MODE_APPROX}; functions for exact and approximate cell equations; parameter checks for W, APPROX_COLS, STAGES.
- Sub-module compressor42_cell: combinational, ports x[4:1], cin, approx_en → s, c, cout. Instantiated W times via generate. approx_en is tied low for columns ≥ APPROX_COLS.
- Stage registers and handshake logic live in the top module.

## Test plan
- Exact, W=8: a=b=c=d=8'hFF, mode 0 -> sum_o+carry_o = 1020 (10'h3FC), latency = STAGES.
- Approx, APPROX_COLS=4: all operands 8'h01, mode 1 -> sum_o+carry_o = 2. The same operands with mode 0 give 4.
- Random exact sweep of 10k beats with random out_ready, both STAGES values -> every beat equals the operand sum, in order, with none lost or duplicated.
- Back-to-back beats with out_ready=1 -> one output per cycle, in_ready never drops.
- Stall: out_ready=0 for 5 cycles with pipe full -> in_ready=0, outputs frozen. On release, beats drain in order.
- Assert rst mid-stream with 2 beats in flight -> outputs 0 and out_valid=0 immediately. After release, a new beat yields the correct sum with no stale data.
